// File: rtl/axi_transaction_timer_mc_if.sv
// ---------------------------------------------------------------------------
// axi_transaction_timer_mc_if
// Carries the AXI address-channel signals that the latency timer snoops.
// Only the AW/AR handshakes and their addresses are needed. Every signal is
// passively observed by the timer.
//   awvalid/awready/awaddr : write-address channel
//   arvalid/arready/araddr : read-address channel
// Modports:
//   master : the side that drives the observed bus (bus fabric or bench)
//   slave  : the snooping timer, which only reads the signals
// ---------------------------------------------------------------------------
interface axi_transaction_timer_mc_if #(
  parameter int ADDR_SIZE = 32
);
  logic                 awvalid;
  logic                 awready;
  logic [ADDR_SIZE-1:0] awaddr;
  logic                 arvalid;
  logic                 arready;
  logic [ADDR_SIZE-1:0] araddr;

  modport master (
    output awvalid, awready, awaddr,
    output arvalid, arready, araddr
  );

  modport slave (
    input awvalid, awready, awaddr,
    input arvalid, arready, araddr
  );
endinterface

// File: rtl/axi_transaction_timer_mc.sv
// ---------------------------------------------------------------------------
// axi_transaction_timer_mc
// Multi-channel AXI transaction latency timer. For each of NUM_CH channels it
// counts the cycles from a start-address handshake to a stop-address
// handshake. It keeps the last, max and count statistics for each channel.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   axi               : snooped AW/AR handshake and address (slave modport)
//   i_start_address   : per-channel start address, ch k at [k*REG_SIZE +: REG_SIZE]
//   i_stop_address    : per-channel stop address, same packing
//   i_start_sel       : 0 = start on AW handshake, 1 = start on AR handshake
//   i_stop_sel        : 0 = stop on AW handshake, 1 = stop on AR handshake
//   i_enable          : channel enable (abort when dropped mid-measurement)
//   i_continuous      : 1 = re-arm after each measurement, 0 = one-shot
//   i_clear           : pulse, clears max/count/overflow of the channel
//   o_valid           : 1-cycle pulse when o_time has a new value
//   o_time            : last measured latency
//   o_max_time        : largest latency since reset/clear
//   o_done_count      : completed measurements, saturating
//   o_overflow        : sticky, the time counter saturated
//   o_busy            : channel in ARM/WAIT_START/MEASURE
//   o_waiting         : channel in WAIT_START
// ---------------------------------------------------------------------------
module axi_transaction_timer_mc #(
  parameter int NUM_CH    = 4,
  parameter int REG_SIZE  = 32,
  parameter int ADDR_SIZE = 32,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  axi_transaction_timer_mc_if.slave  axi,
  input  logic [NUM_CH*REG_SIZE-1:0] i_start_address,
  input  logic [NUM_CH*REG_SIZE-1:0] i_stop_address,
  input  logic [NUM_CH-1:0]          i_start_sel,
  input  logic [NUM_CH-1:0]          i_stop_sel,
  input  logic [NUM_CH-1:0]          i_enable,
  input  logic [NUM_CH-1:0]          i_continuous,
  input  logic [NUM_CH-1:0]          i_clear,
  output logic [NUM_CH-1:0]          o_valid,
  output logic [NUM_CH*REG_SIZE-1:0] o_time,
  output logic [NUM_CH*REG_SIZE-1:0] o_max_time,
  output logic [NUM_CH*CNT_W-1:0]    o_done_count,
  output logic [NUM_CH-1:0]          o_overflow,
  output logic [NUM_CH-1:0]          o_busy,
  output logic [NUM_CH-1:0]          o_waiting
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARM        = 2'd1,
    WAIT_START = 2'd2,
    MEASURE    = 2'd3
  } state_t;

  localparam logic [REG_SIZE-1:0] TIME_MAX = {REG_SIZE{1'b1}};
  localparam logic [CNT_W-1:0]    DONE_MAX = {CNT_W{1'b1}};

  logic aw_fire;
  logic ar_fire;

  assign aw_fire = axi.awvalid & axi.awready;
  assign ar_fire = axi.arvalid & axi.arready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t                state_reg;
    state_t                state_next;
    logic [REG_SIZE-1:0]   cnt_reg;
    logic                  enable_d_reg;
    logic                  valid_reg;
    logic [REG_SIZE-1:0]   time_reg;
    logic [REG_SIZE-1:0]   max_reg;
    logic [CNT_W-1:0]      done_reg;
    logic                  ovf_reg;

    logic [REG_SIZE-1:0]   start_cfg;
    logic [REG_SIZE-1:0]   stop_cfg;
    logic                  start_hit;
    logic                  stop_hit;
    logic                  enable_rise;
    logic                  enable;
    logic                  capture;
    logic                  start_accept;
    logic                  busy;
    logic                  waiting;
    logic [REG_SIZE-1:0]   max_base;
    logic [CNT_W-1:0]      done_base;
    logic                  ovf_base;

    assign start_cfg = i_start_address[gi*REG_SIZE +: REG_SIZE];
    assign stop_cfg  = i_stop_address[gi*REG_SIZE +: REG_SIZE];
    assign enable    = i_enable[gi];

    // Only the low ADDR_SIZE bits of the configuration are compared.
    assign start_hit = i_start_sel[gi]
                     ? (ar_fire && (axi.araddr == start_cfg[ADDR_SIZE-1:0]))
                     : (aw_fire && (axi.awaddr == start_cfg[ADDR_SIZE-1:0]));
    assign stop_hit  = i_stop_sel[gi]
                     ? (ar_fire && (axi.araddr == stop_cfg[ADDR_SIZE-1:0]))
                     : (aw_fire && (axi.awaddr == stop_cfg[ADDR_SIZE-1:0]));

    assign enable_rise = enable & ~enable_d_reg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg <= IDLE;
      end else begin
        state_reg <= state_next;
      end
    end

    // Next-state logic. A dropped enable always wins, so an abort takes
    // priority over a stop (or start) hit in the same cycle.
    always_comb begin
      state_next = state_reg;
      case (state_reg)
        IDLE: begin
          if (enable_rise || (enable && i_continuous[gi])) state_next = ARM;
        end
        ARM: begin
          state_next = WAIT_START;
        end
        WAIT_START: begin
          if (!enable)        state_next = IDLE;
          else if (start_hit) state_next = MEASURE;
        end
        MEASURE: begin
          if (!enable)       state_next = IDLE;
          else if (stop_hit) state_next = i_continuous[gi] ? WAIT_START : IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    // Output / control decode
    always_comb begin
      capture      = (state_reg == MEASURE) && enable && stop_hit;
      start_accept = (state_reg == WAIT_START) && enable && start_hit;
      busy         = (state_reg != IDLE);
      waiting      = (state_reg == WAIT_START);
    end

    // Time counter. It holds 1 in the cycle after the start hit, so a stop
    // hit E-S cycles after the start sees exactly E-S.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg      <= '0;
        enable_d_reg <= 1'b0;
      end else begin
        enable_d_reg <= enable;
        if (state_reg == ARM) begin
          cnt_reg <= '0;
        end else if (start_accept) begin
          cnt_reg <= REG_SIZE'(1);
        end else if (state_reg == MEASURE && cnt_reg != TIME_MAX) begin
          cnt_reg <= cnt_reg + REG_SIZE'(1);
        end
      end
    end

    // A clear is applied before a coincident capture or overflow, so that
    // capture becomes the first sample after the clear.
    always_comb begin
      max_base  = i_clear[gi] ? '0   : max_reg;
      done_base = i_clear[gi] ? '0   : done_reg;
      ovf_base  = i_clear[gi] ? 1'b0 : ovf_reg;
    end

    // Statistics
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        time_reg  <= '0;
        max_reg   <= '0;
        done_reg  <= '0;
        ovf_reg   <= 1'b0;
      end else begin
        valid_reg <= capture;
        if (capture) begin
          time_reg <= cnt_reg;
        end
        max_reg  <= (capture && cnt_reg > max_base) ? cnt_reg : max_base;
        done_reg <= (capture && done_base != DONE_MAX) ? done_base + CNT_W'(1) : done_base;
        ovf_reg  <= ovf_base | ((state_reg == MEASURE) && (cnt_reg == TIME_MAX));
      end
    end

    assign o_valid[gi]                          = valid_reg;
    assign o_time[gi*REG_SIZE +: REG_SIZE]      = time_reg;
    assign o_max_time[gi*REG_SIZE +: REG_SIZE]  = max_reg;
    assign o_done_count[gi*CNT_W +: CNT_W]      = done_reg;
    assign o_overflow[gi]                       = ovf_reg;
    assign o_busy[gi]                           = busy;
    assign o_waiting[gi]                        = waiting;
  end

endmodule

// File: tb/tb_axi_transaction_timer_mc.sv
// ---------------------------------------------------------------------------
// tb_axi_transaction_timer_mc
// Directed bench for the multi-channel latency timer. A 4-channel 32-bit
// instance covers the main behaviour. A 1-channel instance with an 8-bit
// counter and a 2-bit done counter covers the saturation corners.
// ---------------------------------------------------------------------------
module tb_axi_transaction_timer_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int fail_count = 0;

  // ---------------- main instance: 4 channels, 32-bit ----------------
  axi_transaction_timer_mc_if #(.ADDR_SIZE(32)) bus ();

  logic [127:0] start_address;
  logic [127:0] stop_address;
  logic [3:0]   start_sel, stop_sel, enable, continuous, clear;
  logic [3:0]   valid, overflow, busy, waiting;
  logic [127:0] time_v, max_v;
  logic [63:0]  done_v;

  axi_transaction_timer_mc #(
    .NUM_CH(4), .REG_SIZE(32), .ADDR_SIZE(32), .CNT_W(16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .axi             (bus),
    .i_start_address (start_address),
    .i_stop_address  (stop_address),
    .i_start_sel     (start_sel),
    .i_stop_sel      (stop_sel),
    .i_enable        (enable),
    .i_continuous    (continuous),
    .i_clear         (clear),
    .o_valid         (valid),
    .o_time          (time_v),
    .o_max_time      (max_v),
    .o_done_count    (done_v),
    .o_overflow      (overflow),
    .o_busy          (busy),
    .o_waiting       (waiting)
  );

  // ---------------- small instance: 1 channel, 8-bit -----------------
  axi_transaction_timer_mc_if #(.ADDR_SIZE(8)) bus_s ();

  logic [7:0] s_start_address, s_stop_address;
  logic       s_start_sel, s_stop_sel, s_enable, s_continuous, s_clear;
  logic       s_valid, s_overflow, s_busy, s_waiting;
  logic [7:0] s_time, s_max;
  logic [1:0] s_done;

  axi_transaction_timer_mc #(
    .NUM_CH(1), .REG_SIZE(8), .ADDR_SIZE(8), .CNT_W(2)
  ) dut_s (
    .clk             (clk),
    .rst_n           (rst_n),
    .axi             (bus_s),
    .i_start_address (s_start_address),
    .i_stop_address  (s_stop_address),
    .i_start_sel     (s_start_sel),
    .i_stop_sel      (s_stop_sel),
    .i_enable        (s_enable),
    .i_continuous    (s_continuous),
    .i_clear         (s_clear),
    .o_valid         (s_valid),
    .o_time          (s_time),
    .o_max_time      (s_max),
    .o_done_count    (s_done),
    .o_overflow      (s_overflow),
    .o_busy          (s_busy),
    .o_waiting       (s_waiting)
  );

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle handshake on the main bus (ar=0: AW channel, ar=1: AR channel).
  task automatic hit(input bit ar, input logic [31:0] a);
    $display("[TB] t=%0t main %s handshake addr=0x%0h", $time, ar ? "AR" : "AW", a);
    if (ar) begin
      bus.arvalid = 1'b1; bus.arready = 1'b1; bus.araddr = a;
    end else begin
      bus.awvalid = 1'b1; bus.awready = 1'b1; bus.awaddr = a;
    end
    tick();
    bus.awvalid = 1'b0; bus.awready = 1'b0;
    bus.arvalid = 1'b0; bus.arready = 1'b0;
  endtask

  task automatic hit_s(input bit ar, input logic [7:0] a);
    $display("[TB] t=%0t small %s handshake addr=0x%0h", $time, ar ? "AR" : "AW", a);
    if (ar) begin
      bus_s.arvalid = 1'b1; bus_s.arready = 1'b1; bus_s.araddr = a;
    end else begin
      bus_s.awvalid = 1'b1; bus_s.awready = 1'b1; bus_s.awaddr = a;
    end
    tick();
    bus_s.awvalid = 1'b0; bus_s.awready = 1'b0;
    bus_s.arvalid = 1'b0; bus_s.arready = 1'b0;
  endtask

  // Global time bound.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Bus idle
    bus.awvalid = 0; bus.awready = 0; bus.awaddr = '0;
    bus.arvalid = 0; bus.arready = 0; bus.araddr = '0;
    bus_s.awvalid = 0; bus_s.awready = 0; bus_s.awaddr = '0;
    bus_s.arvalid = 0; bus_s.arready = 0; bus_s.araddr = '0;

    // ch0: AW 0x1000 -> AR 0x1000, one-shot
    // ch1: AW 0x2000 -> AR 0x2004, continuous
    // ch2: AW 0x3000 -> AW 0x3000, one-shot
    // ch3: AR 0x4000 -> AR 0x4004, continuous
    start_address = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    stop_address  = {32'h4004, 32'h3000, 32'h2004, 32'h1000};
    start_sel  = 4'b1000;
    stop_sel   = 4'b1011;
    continuous = 4'b1010;
    enable     = 4'b0000;
    clear      = 4'b0000;

    s_start_address = 8'h10; s_stop_address = 8'h20;
    s_start_sel = 1'b0; s_stop_sel = 1'b1;
    s_enable = 1'b0; s_continuous = 1'b0; s_clear = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check_eq("rst_valid",    64'(valid),   64'h0);
    check_eq("rst_busy",     64'(busy),    64'h0);
    check_eq("rst_waiting",  64'(waiting), 64'h0);
    check_eq("rst_time_lo",  time_v[63:0],   64'h0);
    check_eq("rst_time_hi",  time_v[127:64], 64'h0);
    check_eq("rst_done",     done_v,         64'h0);
    check_eq("rst_s_time",   64'(s_time),    64'h0);
    #2 rst_n = 1'b1;
    tick();

    // ---------------- 1: ch0 one-shot, latency 5 ----------------
    enable[0] = 1'b1;
    tick(); tick();
    check_eq("t1_waiting", 64'(waiting), 64'b0001);
    check_eq("t1_busy",    64'(busy),    64'b0001);
    hit(1'b0, 32'h1000);              // start at S
    repeat (4) tick();
    hit(1'b1, 32'h1000);              // stop at S+5
    check_eq("t1_valid", 64'(valid), 64'b0001);
    check_eq("t1_time",  64'(time_v[31:0]), 64'd5);
    check_eq("t1_max",   64'(max_v[31:0]),  64'd5);
    check_eq("t1_count", 64'(done_v[15:0]), 64'd1);
    tick();
    check_eq("t1_valid_pulse", 64'(valid), 64'b0000);
    check_eq("t1_idle",        64'(busy[0]), 64'd0);
    repeat (3) tick();
    check_eq("t1_no_rearm_held", 64'(busy[0]), 64'd0);

    // ---------------- 3: qualification of start hits ----------------
    enable[0] = 1'b0; tick();
    enable[0] = 1'b1; tick(); tick();
    check_eq("t3_rearm", 64'(waiting[0]), 64'd1);
    bus.awvalid = 1'b1; bus.awready = 1'b0; bus.awaddr = 32'h1000;
    tick();
    bus.awvalid = 1'b0;
    check_eq("t3_no_ready", 64'(waiting[0]), 64'd1);
    hit(1'b0, 32'h1004);
    check_eq("t3_wrong_addr", 64'(waiting[0]), 64'd1);
    hit(1'b1, 32'h1000);              // stop address is not a start
    check_eq("t3_stop_in_wait", 64'(waiting[0]), 64'd1);
    check_eq("t3_stop_no_valid", 64'(valid[0]), 64'd0);
    // A second start hit while measuring does not restart the count.
    hit(1'b0, 32'h1000);              // S
    tick();
    hit(1'b0, 32'h1000);              // S+2, ignored
    tick();
    hit(1'b1, 32'h1000);              // S+4
    check_eq("t3_norestart_time",  64'(time_v[31:0]), 64'd4);
    check_eq("t3_norestart_max",   64'(max_v[31:0]),  64'd5);
    check_eq("t3_norestart_count", 64'(done_v[15:0]), 64'd2);
    enable[0] = 1'b0;

    // ---------------- 2: ch1 continuous 3, 7, 2 ----------------
    enable[1] = 1'b1;
    tick(); tick();
    check_eq("t2_waiting", 64'(waiting[1]), 64'd1);
    hit(1'b0, 32'h2000);
    repeat (2) tick();
    hit(1'b1, 32'h2004);
    check_eq("t2_valid_a", 64'(valid), 64'b0010);
    check_eq("t2_time_a",  64'(time_v[63:32]), 64'd3);
    hit(1'b0, 32'h2000);              // start right at E+1
    repeat (6) tick();
    hit(1'b1, 32'h2004);
    check_eq("t2_valid_b", 64'(valid[1]), 64'd1);
    check_eq("t2_time_b",  64'(time_v[63:32]), 64'd7);
    hit(1'b0, 32'h2000);
    tick();
    hit(1'b1, 32'h2004);
    check_eq("t2_time_c",  64'(time_v[63:32]), 64'd2);
    check_eq("t2_max",     64'(max_v[63:32]),  64'd7);
    check_eq("t2_count",   64'(done_v[31:16]), 64'd3);
    check_eq("t2_rewait",  64'(waiting[1]),    64'd1);
    enable[1] = 1'b0;
    tick();

    // ---------------- ch2: start and stop on the same handshake ------
    enable[2] = 1'b1;
    tick(); tick();
    hit(1'b0, 32'h3000);              // start only
    check_eq("same_valid",   64'(valid[2]),   64'd0);
    check_eq("same_measure", 64'({busy[2], waiting[2]}), 64'b10);
    repeat (3) tick();
    hit(1'b0, 32'h3000);              // stop 4 cycles later
    check_eq("same_time",  64'(time_v[95:64]), 64'd4);
    check_eq("same_count", 64'(done_v[47:32]), 64'd1);

    // ---------------- 4: abort beats a same-cycle stop ----------------
    enable[2] = 1'b0; tick();
    enable[2] = 1'b1; tick(); tick();
    hit(1'b0, 32'h3000);
    repeat (2) tick();
    enable[2] = 1'b0;
    hit(1'b0, 32'h3000);
    check_eq("t4_valid", 64'(valid[2]), 64'd0);
    check_eq("t4_idle",  64'(busy[2]),  64'd0);
    check_eq("t4_time",  64'(time_v[95:64]), 64'd4);
    check_eq("t4_max",   64'(max_v[95:64]),  64'd4);
    check_eq("t4_count", 64'(done_v[47:32]), 64'd1);

    // ---------------- 6: clear coincident with capture ----------------
    enable[3] = 1'b1;
    tick(); tick();
    hit(1'b1, 32'h4000);
    repeat (19) tick();
    hit(1'b1, 32'h4004);              // 20
    for (int i = 0; i < 3; i++) begin
      hit(1'b1, 32'h4000);
      repeat (4) tick();
      hit(1'b1, 32'h4004);            // 5
    end
    check_eq("t6_pre_max",   64'(max_v[127:96]),  64'd20);
    check_eq("t6_pre_count", 64'(done_v[63:48]),  64'd4);
    hit(1'b1, 32'h4000);
    repeat (8) tick();
    clear = 4'b1000;
    hit(1'b1, 32'h4004);              // 9, with clear
    clear = 4'b0000;
    check_eq("t6_valid", 64'(valid[3]), 64'd1);
    check_eq("t6_time",  64'(time_v[127:96]), 64'd9);
    check_eq("t6_max",   64'(max_v[127:96]),  64'd9);
    check_eq("t6_count", 64'(done_v[63:48]),  64'd1);
    check_eq("t6_ovf",   64'(overflow[3]),    64'd0);
    // A clear on its own leaves o_time alone.
    clear = 4'b0001;
    tick();
    clear = 4'b0000;
    check_eq("clr_max",   64'(max_v[31:0]),  64'd0);
    check_eq("clr_count", 64'(done_v[15:0]), 64'd0);
    check_eq("clr_time",  64'(time_v[31:0]), 64'd4);

    // ---------------- 5: 8-bit counter saturation ----------------
    s_enable = 1'b1;
    tick(); tick();
    hit_s(1'b0, 8'h10);
    repeat (300) tick();
    check_eq("t5_ovf",   64'(s_overflow), 64'd1);
    check_eq("t5_busy",  64'(s_busy),     64'd1);
    hit_s(1'b1, 8'h20);
    check_eq("t5_valid", 64'(s_valid), 64'd1);
    check_eq("t5_time",  64'(s_time),  64'd255);
    tick();
    check_eq("t5_idle",  64'(s_busy),  64'd0);
    // Done counter saturates at 3 with CNT_W=2.
    s_continuous = 1'b1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      hit_s(1'b0, 8'h10);
      tick();
      hit_s(1'b1, 8'h20);
    end
    check_eq("sat_count", 64'(s_done),     64'd3);
    check_eq("sat_time",  64'(s_time),     64'd2);
    check_eq("sat_max",   64'(s_max),      64'd255);
    check_eq("sat_ovf",   64'(s_overflow), 64'd1);
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    check_eq("sclr_ovf",   64'(s_overflow), 64'd0);
    check_eq("sclr_count", 64'(s_done),     64'd0);
    check_eq("sclr_max",   64'(s_max),      64'd0);

    // ---------------- async reset mid-MEASURE ----------------
    hit(1'b1, 32'h4000);              // ch3 measuring
    repeat (3) tick();
    check_eq("ar_pre_busy", 64'(busy[3]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_busy",    64'(busy),    64'h0);
    check_eq("ar_waiting", 64'(waiting), 64'h0);
    check_eq("ar_time",    time_v[127:64] | time_v[63:0], 64'h0);
    check_eq("ar_max",     max_v[127:64] | max_v[63:0],   64'h0);
    check_eq("ar_done",    done_v,       64'h0);
    check_eq("ar_s_busy",  64'(s_busy),  64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
